// File: rtl/commit_monitor_if.sv
// Retirement stream in, trace record stream out; the monitor takes the slave view.
interface commit_monitor_if;
  logic        commit;
  logic [31:0] commit_instr;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;

  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_instr;
  logic [63:0] trace_pc;
  logic [63:0] trace_pre_pc;
  logic [63:0] trace_seq;

  modport master (
    output commit, commit_instr, commit_pc, commit_pre_pc, trace_ready,
    input  trace_valid, trace_instr, trace_pc, trace_pre_pc, trace_seq
  );

  modport slave (
    input  commit, commit_instr, commit_pc, commit_pre_pc, trace_ready,
    output trace_valid, trace_instr, trace_pc, trace_pre_pc, trace_seq
  );
endinterface

// File: rtl/commit_monitor.sv
// Commit trace/run-control: 1-cycle commit-to-trace latency through a DEPTH-entry FIFO.
// Never stalls the commit stream; a record arriving at a full FIFO is dropped and flagged.
module commit_monitor #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  commit_monitor_if.slave          mon,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [63:0]              instret,
  output logic [63:0]              cycles,
  output logic                     halted,
  output logic [63:0]              halt_pc,
  output logic                     timeout,
  output logic                     overflow
);

  localparam int          PtrW   = $clog2(DEPTH);
  localparam int          CntW   = PtrW + 1;
  localparam int          IdleW  = $clog2(TIMEOUT);
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef enum logic [1:0] {
    stRun,
    stHalted,
    stTimeout
  } state_t;

  state_t state;
  state_t stateNext;

  logic [PtrW-1:0]  rdPtr;
  logic [PtrW-1:0]  wrPtr;
  logic [IdleW-1:0] idleCnt;

  logic [31:0] instrMem [DEPTH];
  logic [63:0] pcMem    [DEPTH];
  logic [63:0] prePcMem [DEPTH];
  logic [63:0] seqMem   [DEPTH];

  logic running;
  logic accept;
  logic headVld;
  logic pop;
  logic space;
  logic push;
  logic drop;
  logic isEbreak;
  logic idleExpire;

  assign running    = (state == stRun);
  assign accept     = running & mon.commit;
  assign headVld    = (fifo_count != '0);
  assign pop        = headVld & mon.trace_ready;
  // A full FIFO still has room when its head leaves on the same edge.
  assign space      = (fifo_count != CntW'(DEPTH)) | pop;
  assign push       = accept & space;
  assign drop       = accept & ~space;
  assign isEbreak   = accept & (mon.commit_instr == Ebreak);
  assign idleExpire = running & ~mon.commit & (idleCnt == IdleW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= stRun;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      stRun: begin
        if (isEbreak) begin
          stateNext = stHalted;
        end else if (idleExpire) begin
          stateNext = stTimeout;
        end
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
      instret    <= '0;
      cycles     <= '0;
      idleCnt    <= '0;
      overflow   <= 1'b0;
      halt_pc    <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (accept) begin
        instret <= instret + 64'd1;
      end
      if (running) begin
        cycles <= cycles + 64'd1;
      end

      if (accept) begin
        idleCnt <= '0;
      end else if (running && !idleExpire) begin
        idleCnt <= idleCnt + 1'b1;
      end

      if (drop) begin
        overflow <= 1'b1;
      end
      if (isEbreak) begin
        halt_pc <= mon.commit_pc;
      end
    end
  end

  // Record storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instrMem[wrPtr] <= mon.commit_instr;
      pcMem[wrPtr]    <= mon.commit_pc;
      prePcMem[wrPtr] <= mon.commit_pre_pc;
      seqMem[wrPtr]   <= instret;
    end
  end

  assign mon.trace_valid  = headVld;
  assign mon.trace_instr  = headVld ? instrMem[rdPtr] : '0;
  assign mon.trace_pc     = headVld ? pcMem[rdPtr]    : '0;
  assign mon.trace_pre_pc = headVld ? prePcMem[rdPtr] : '0;
  assign mon.trace_seq    = headVld ? seqMem[rdPtr]   : '0;

  assign halted  = (state == stHalted);
  assign timeout = (state == stTimeout);

endmodule
